// File: rtl/conv_pkg.sv
// Shared constants for the K=7 convolutional frame controller: rate codes,
// generator taps, puncture keep masks and the controller state encoding.
package conv_pkg;

    localparam int K        = 7;
    localparam int SR_W     = K - 1;
    localparam int TAIL_LEN = 6;

    // Taps ordered {d, s1, s2, s3, s4, s5, s6}
    localparam logic [K-1:0] G0 = 7'o133;
    localparam logic [K-1:0] G1 = 7'o171;

    localparam logic [1:0] RATE_1_2 = 2'b00;
    localparam logic [1:0] RATE_2_3 = 2'b01;
    localparam logic [1:0] RATE_3_4 = 2'b10;

    // Each entry is {keep_a, keep_b}, indexed by puncture phase
    localparam logic [1:0]       MASK_1_2 = 2'b11;
    localparam logic [3:0][1:0]  MASK_2_3 = {2'b11, 2'b11, 2'b10, 2'b11};
    localparam logic [3:0][1:0]  MASK_3_4 = {2'b11, 2'b01, 2'b10, 2'b11};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_TAIL  = 2'd2,
        ST_DRAIN = 2'd3
    } conv_state_e;

    function automatic logic [1:0] punct_period(input logic [1:0] rate);
        case (rate)
            RATE_2_3: return 2'd2;
            RATE_3_4: return 2'd3;
            default:  return 2'd1;
        endcase
    endfunction

    // Reserved rate code falls back to 1/2
    function automatic logic [1:0] keep_mask(input logic [1:0] rate, input logic [1:0] phase);
        case (rate)
            RATE_1_2: return MASK_1_2;
            RATE_2_3: return MASK_2_3[phase];
            RATE_3_4: return MASK_3_4[phase];
            default:  return MASK_1_2;
        endcase
    endfunction

endpackage

// File: rtl/conv_frame_ctrl_if.sv
// Frame control and bit-stream handshake bundle between the upstream source,
// the encoder controller and the downstream sink.
interface conv_frame_ctrl_if;
    logic        start;
    logic [1:0]  rate;
    logic [15:0] num_bits;
    logic        in_valid;
    logic        in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_data;
    logic        out_ready;
    logic        busy;
    logic        done;

    modport master (
        output start, rate, num_bits, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  start, rate, num_bits, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/conv_core.sv
// K=7 encoder: 6-bit history register plus the two generator parity outputs
// computed combinationally from the incoming bit.
module conv_core
    import conv_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic d_i,
    output logic a_o,
    output logic b_o
);

    // sr_q[SR_W-1] is s1 (most recent), sr_q[0] is s6
    logic [SR_W-1:0] sr_q, sr_d;
    logic [K-1:0]    taps;

    assign taps = {d_i, sr_q};
    assign a_o  = ^(taps & G0);
    assign b_o  = ^(taps & G1);

    always_comb begin
        sr_d = sr_q;
        if (clr_i)
            sr_d = '0;
        else if (en_i)
            sr_d = {d_i, sr_q[SR_W-1:1]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            sr_q <= '0;
        else
            sr_q <= sr_d;
    end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the punctured K=7 encoder: data/tail pacing, the A/B
// hold buffer, puncture phase and output serialisation.
//   state    | meaning
//   IDLE     | waiting for start, outputs quiet
//   DATA     | consuming upstream data bits
//   TAIL     | injecting zero flush bits
//   DRAIN    | emptying the last held pair, then done
module conv_frame_ctrl
    import conv_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    conv_frame_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_DATA  = ST_DATA;
    localparam logic [1:0] S_TAIL  = ST_TAIL;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;

    logic [1:0]  state_q, state_d;
    logic [1:0]  rate_q, rate_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  phase_q, phase_d;
    logic        hold_a_q, hold_a_d, hold_b_q, hold_b_d;
    logic        keep_a_q, keep_a_d, keep_b_q, keep_b_d;
    logic        done_q, done_d;

    logic        hold_empty, hold_free, xfer, enc_en, enc_d, enc_a, enc_b, start_ok;
    logic [1:0]  mask;

    assign hold_empty = !(keep_a_q || keep_b_q);
    assign xfer       = !hold_empty && bus.out_ready;
    // The buffer can take a new pair when empty or when its only remaining entry leaves now
    assign hold_free  = hold_empty || (xfer && !(keep_a_q && keep_b_q));
    assign enc_en     = hold_free && ((state_q == S_DATA && bus.in_valid) || state_q == S_TAIL);
    assign enc_d      = (state_q == S_DATA) && bus.in_data;
    assign start_ok   = (state_q == S_IDLE) && bus.start;
    assign mask       = keep_mask(rate_q, phase_q);

    conv_core u_core (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (start_ok),
        .en_i  (enc_en),
        .d_i   (enc_d),
        .a_o   (enc_a),
        .b_o   (enc_b)
    );

    always_comb begin
        state_d  = state_q;
        rate_d   = rate_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        hold_a_d = hold_a_q;
        hold_b_d = hold_b_q;
        keep_a_d = keep_a_q;
        keep_b_d = keep_b_q;
        done_d   = 1'b0;

        if (xfer) begin
            if (keep_a_q)
                keep_a_d = 1'b0;
            else
                keep_b_d = 1'b0;
        end

        if (enc_en) begin
            hold_a_d = enc_a;
            hold_b_d = enc_b;
            keep_a_d = mask[1];
            keep_b_d = mask[0];
            phase_d  = (phase_q == punct_period(rate_q) - 2'd1) ? 2'd0 : phase_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rate_d  = bus.rate;
                    phase_d = 2'd0;
                    if (bus.num_bits == 16'd0) begin
                        state_d = S_TAIL;
                        cnt_d   = 16'(TAIL_LEN);
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = bus.num_bits;
                    end
                end
            end
            S_DATA: begin
                if (enc_en) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = S_TAIL;
                        cnt_d   = 16'(TAIL_LEN);
                    end
                end
            end
            S_TAIL: begin
                if (enc_en) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1)
                        state_d = S_DRAIN;
                end
            end
            default: begin
                if (hold_empty) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            rate_q   <= '0;
            cnt_q    <= '0;
            phase_q  <= '0;
            hold_a_q <= 1'b0;
            hold_b_q <= 1'b0;
            keep_a_q <= 1'b0;
            keep_b_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rate_q   <= rate_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
            keep_a_q <= keep_a_d;
            keep_b_q <= keep_b_d;
            done_q   <= done_d;
        end
    end

    assign bus.in_ready  = (state_q == S_DATA) && hold_free;
    assign bus.out_valid = !hold_empty;
    assign bus.out_data  = keep_a_q ? hold_a_q : (keep_b_q && hold_b_q);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl against a sequence-level encoder model.
module tb_conv_frame_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_frame_ctrl_if bus_if ();

    conv_frame_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit din [64];
    bit seq_q [$];
    bit exp_q [$];
    bit got_q [$];
    bit keep_q [$];

    int done_cnt, done_cyc, last_xfer, first_in, first_out, stab_err, ir_seen;

    function automatic bit past(input int i, input int k);
        return (i - k >= 0) ? seq_q[i - k] : 1'b0;
    endfunction

    // Reference: encode data followed by six zeros, then drop bits by rate pattern
    task automatic build_expected(input logic [1:0] r, input int n);
        int per, p;
        bit a, b;
        seq_q.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) seq_q.push_back(din[i]);
        for (int i = 0; i < 6; i++) seq_q.push_back(1'b0);
        per = (r == 2'b01) ? 2 : (r == 2'b10) ? 3 : 1;
        for (int i = 0; i < seq_q.size(); i++) begin
            a = seq_q[i] ^ past(i, 2) ^ past(i, 3) ^ past(i, 5) ^ past(i, 6);
            b = seq_q[i] ^ past(i, 1) ^ past(i, 2) ^ past(i, 3) ^ past(i, 6);
            p = i % per;
            if (!(per == 3 && p == 2)) exp_q.push_back(a);
            if (!(per > 1 && p == 1))  exp_q.push_back(b);
        end
    endtask

    task automatic idle_inputs();
        bus_if.start     = 1'b0;
        bus_if.rate      = 2'b00;
        bus_if.num_bits  = 16'd0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = 1'b0;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic run_frame(input logic [1:0] r, input int n, input bit gap, input int start_at);
        int  cyc, idx;
        bit  prev_stall, prev_data;
        got_q.delete();
        done_cnt = 0; done_cyc = -1; last_xfer = -1; first_in = -1; first_out = -1;
        stab_err = 0; ir_seen = 0; cyc = 0; idx = 0; prev_stall = 0; prev_data = 0;
        @(negedge clk);
        bus_if.start    = 1'b1;
        bus_if.rate     = r;
        bus_if.num_bits = 16'(n);
        @(negedge clk);
        while (cyc < 3000 && !(done_cnt > 0 && cyc > done_cyc + 4)) begin
            if (prev_stall && !(bus_if.out_valid === 1'b1 && bus_if.out_data === prev_data))
                stab_err++;
            if (first_out < 0 && bus_if.out_valid === 1'b1) first_out = cyc;
            if (bus_if.done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            bus_if.start     = (cyc == start_at);
            bus_if.rate      = 2'($urandom_range(0, 3));
            bus_if.num_bits  = 16'($urandom_range(0, 40));
            bus_if.out_ready = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_if.in_valid  = (idx < n) && (gap ? ($urandom_range(0, 2) != 0) : 1'b1);
            bus_if.in_data   = (idx < n) ? din[idx] : 1'($urandom_range(0, 1));
            #1;
            if (bus_if.in_ready === 1'b1) ir_seen = 1;
            if (bus_if.in_valid && bus_if.in_ready === 1'b1) begin
                if (first_in < 0) first_in = cyc;
                idx++;
            end
            if (bus_if.out_valid === 1'b1 && bus_if.out_ready) begin
                got_q.push_back(bus_if.out_data);
                last_xfer = cyc;
            end
            prev_stall = (bus_if.out_valid === 1'b1) && !bus_if.out_ready;
            prev_data  = bus_if.out_data;
            @(negedge clk);
            cyc++;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        idle_inputs();
        bus_if.start    = 1'b1;
        bus_if.num_bits = 16'd5;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        obs = {bus_if.in_ready, bus_if.out_valid, bus_if.out_data, bus_if.busy, bus_if.done};
        n_checks++;
        if (obs !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 00000", obs);
        end
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b, expected 0", bus_if.busy);
        end
    endtask

    task automatic test_impulse();
        logic [13:0] imp;
        int mism;
        imp = 14'b11011111001011;
        exp_q.delete();
        for (int i = 13; i >= 0; i--) exp_q.push_back(imp[i]);
        din[0] = 1'b1;
        run_frame(2'b00, 1, 1'b0, -1);
        mism = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) mism++;
        n_checks++;
        if (got_q.size() != 14) begin
            n_fail++;
            $display("FAIL impulse_len: got %0d bits, expected 14", got_q.size());
        end
        n_checks++;
        if (mism != 0) begin
            n_fail++;
            $display("FAIL impulse_bits: got %0d mismatching bits, expected 0", mism);
        end
        n_checks++;
        if (first_out != first_in + 1) begin
            n_fail++;
            $display("FAIL impulse_latency: first output cycle %0d, expected %0d", first_out, first_in + 1);
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc <= last_xfer) begin
            n_fail++;
            $display("FAIL impulse_done: got %0d pulses at cycle %0d (last xfer %0d), expected 1 after", done_cnt, done_cyc, last_xfer);
        end
    endtask

    task automatic test_empty();
        int ones;
        run_frame(2'b10, 0, 1'b0, -1);
        ones = 0;
        foreach (got_q[i]) if (got_q[i] !== 1'b0) ones++;
        n_checks++;
        if (got_q.size() != 8 || ones != 0) begin
            n_fail++;
            $display("FAIL empty_stream: got %0d bits with %0d ones, expected 8 zeros", got_q.size(), ones);
        end
        n_checks++;
        if (ir_seen != 0) begin
            n_fail++;
            $display("FAIL empty_in_ready: in_ready seen %0d, expected 0", ir_seen);
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc <= last_xfer) begin
            n_fail++;
            $display("FAIL empty_done: got %0d pulses at cycle %0d (last xfer %0d), expected 1 after", done_cnt, done_cyc, last_xfer);
        end
    endtask

    task automatic test_rates();
        logic [1:0] r;
        int want, mism;
        for (int k = 0; k < 2; k++) begin
            r    = (k == 0) ? 2'b01 : 2'b10;
            want = (k == 0) ? 18 : 16;
            din[0] = 1; din[1] = 0; din[2] = 1; din[3] = 1; din[4] = 0; din[5] = 0;
            build_expected(r, 6);
            run_frame(r, 6, 1'b0, -1);
            mism = 0;
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                if (got_q[i] !== exp_q[i]) mism++;
            n_checks++;
            if (got_q.size() != want) begin
                n_fail++;
                $display("FAIL rate%0d_len: got %0d bits, expected %0d", r, got_q.size(), want);
            end
            n_checks++;
            if (mism != 0) begin
                n_fail++;
                $display("FAIL rate%0d_bits: got %0d mismatching bits, expected 0", r, mism);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] r;
        int n, mism;
        for (int f = 0; f < 6; f++) begin
            r = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) din[i] = 1'($urandom_range(0, 1));
            build_expected(r, n);
            run_frame(r, n, 1'b1, -1);
            keep_q = got_q;
            mism = 0;
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                if (got_q[i] !== exp_q[i]) mism++;
            n_checks++;
            if (got_q.size() != exp_q.size() || mism != 0) begin
                n_fail++;
                $display("FAIL bp_stream f%0d: got %0d bits (%0d wrong), expected %0d", f, got_q.size(), mism, exp_q.size());
            end
            n_checks++;
            if (stab_err != 0) begin
                n_fail++;
                $display("FAIL bp_stable f%0d: got %0d unstable stalls, expected 0", f, stab_err);
            end
            n_checks++;
            if (done_cnt != 1) begin
                n_fail++;
                $display("FAIL bp_done f%0d: got %0d pulses, expected 1", f, done_cnt);
            end
            run_frame(r, n, 1'b0, -1);
            n_checks++;
            if (got_q != keep_q) begin
                n_fail++;
                $display("FAIL bp_vs_unstalled f%0d: got %0d bits, stalled run had %0d", f, got_q.size(), keep_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        int idx, cyc, dn, mism;
        logic [4:0] obs;
        for (int i = 0; i < 8; i++) din[i] = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.rate = 2'b00; bus_if.num_bits = 16'd8;
        @(negedge clk);
        bus_if.start = 1'b0;
        idx = 0; cyc = 0;
        while (idx < 3 && cyc < 100) begin
            bus_if.out_ready = 1'b1;
            bus_if.in_valid  = 1'b1;
            bus_if.in_data   = din[idx];
            #1;
            if (bus_if.in_ready === 1'b1) idx++;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (idx != 3) begin
            n_fail++;
            $display("FAIL rstmid_consume: got %0d bits consumed, expected 3", idx);
        end
        rst = 1'b1;
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        obs = {bus_if.in_ready, bus_if.out_valid, bus_if.out_data, bus_if.busy, bus_if.done};
        n_checks++;
        if (obs !== 5'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %b, expected 00000", obs);
        end
        rst = 1'b0;
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) dn++;
        end
        n_checks++;
        if (dn != 0) begin
            n_fail++;
            $display("FAIL rstmid_abandon: got %0d done/busy cycles, expected 0", dn);
        end
        build_expected(2'b00, 8);
        run_frame(2'b00, 8, 1'b0, -1);
        mism = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) mism++;
        n_checks++;
        if (got_q.size() != exp_q.size() || mism != 0) begin
            n_fail++;
            $display("FAIL rstmid_fresh: got %0d bits (%0d wrong), expected %0d", got_q.size(), mism, exp_q.size());
        end
    endtask

    task automatic test_start_busy();
        int mism;
        for (int i = 0; i < 10; i++) din[i] = 1'($urandom_range(0, 1));
        build_expected(2'b01, 10);
        run_frame(2'b01, 10, 1'b0, 4);
        mism = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) mism++;
        n_checks++;
        if (got_q.size() != exp_q.size() || mism != 0) begin
            n_fail++;
            $display("FAIL busy_start_stream: got %0d bits (%0d wrong), expected %0d", got_q.size(), mism, exp_q.size());
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL busy_start_done: got %0d pulses, expected 1", done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_empty();
        test_rates();
        test_backpressure();
        test_reset_mid();
        test_start_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
